// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative cache tag/LRU controller: 3-cycle lookup pipeline, per-set true LRU,
// invalidation sweep after reset and on flush, saturating access statistics.
`timescale 1ns/1ps
module set_assoc_cache_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_W    = 2,
    parameter int unsigned INDEX_W     = 14,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned WRITE_ALLOC = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_store,
    input  logic [ADDR_W-1:0]                      req_addr,
    input  logic                                   flush,
    output logic                                   flush_busy,
    output logic                                   rsp_valid,
    output logic                                   rsp_hit,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] rsp_way,
    output logic [CNT_W-1:0]                       load_hits,
    output logic [CNT_W-1:0]                       load_misses,
    output logic [CNT_W-1:0]                       store_hits,
    output logic [CNT_W-1:0]                       store_misses
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned SETS  = 1 << INDEX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, RESP, FLUSH} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INDEX_W-1:0] sweep_idx;
    logic               sweep_last;
    logic               sweeping;
    logic               accept;
    logic               rsp_commit;

    logic               req_store_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_idx_q;
    logic               alloc_q;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];

    logic               hit_c;
    logic [WAY_W-1:0]   hit_way_c;
    logic [WAY_W-1:0]   victim_c;
    logic               free_found_c;
    logic               alloc_c;
    logic [WAY_W-1:0]   cur_age_c;

    // Offset bits only select a byte within the line.
    wire unused_offset = ^req_addr[OFFSET_W-1:0];

    assign sweep_last = (sweep_idx == INDEX_W'(SETS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            INIT, FLUSH: if (sweep_last) state_nxt = IDLE;
            IDLE: begin
                if (flush)          state_nxt = FLUSH;
                else if (req_valid) state_nxt = LOOKUP;
            end
            LOOKUP:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // State-decoded outputs and controls
    always_comb begin
        req_ready  = 1'b0;
        flush_busy = 1'b0;
        sweeping   = 1'b0;
        rsp_commit = 1'b0;
        case (state)
            INIT, FLUSH: begin
                flush_busy = 1'b1;
                sweeping   = 1'b1;
            end
            IDLE:    req_ready  = ~flush;
            RESP:    rsp_commit = 1'b1;
            default: ;
        endcase
    end

    assign accept = req_valid & req_ready;

    // Tag compare, victim choice (first invalid way, else the oldest)
    always_comb begin
        hit_c        = 1'b0;
        hit_way_c    = '0;
        victim_c     = '0;
        free_found_c = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!free_found_c && !valid_q[req_idx_q][w]) begin
                victim_c     = WAY_W'(w);
                free_found_c = 1'b1;
            end
        end
        if (!free_found_c) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx_q][w] == WAY_W'(WAYS - 1)) victim_c = WAY_W'(w);
            end
        end
        alloc_c   = ~hit_c & (~req_store_q | (WRITE_ALLOC != 0));
        cur_age_c = age_q[req_idx_q][rsp_way];
    end

    // Request capture, sweep pointer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_store_q <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            sweep_idx   <= '0;
            alloc_q     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_way     <= '0;
        end else begin
            if (accept) begin
                req_store_q <= req_store;
                req_tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
                req_idx_q   <= req_addr[OFFSET_W +: INDEX_W];
            end
            if (sweeping) sweep_idx <= sweep_idx + INDEX_W'(1);
            rsp_valid <= (state == LOOKUP);
            if (state == LOOKUP) begin
                rsp_hit <= hit_c;
                alloc_q <= alloc_c;
                rsp_way <= hit_c ? hit_way_c : (alloc_c ? victim_c : '0);
            end
        end
    end

    // Tag/valid/LRU arrays: sweep clears one set per cycle, RESP commits the access
    always_ff @(posedge clk) begin
        if (sweeping) begin
            valid_q[sweep_idx] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[sweep_idx][w] <= WAY_W'(w);
        end else if (rsp_commit && (rsp_hit || alloc_q)) begin
            if (alloc_q) begin
                valid_q[req_idx_q][rsp_way] <= 1'b1;
                tag_q[req_idx_q][rsp_way]   <= req_tag_q;
            end
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == rsp_way)
                    age_q[req_idx_q][w] <= '0;
                else if (age_q[req_idx_q][w] < cur_age_c)
                    age_q[req_idx_q][w] <= age_q[req_idx_q][w] + WAY_W'(1);
            end
        end
    end

    // Saturating statistics, one bump per response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_hits    <= '0;
            load_misses  <= '0;
            store_hits   <= '0;
            store_misses <= '0;
        end else if (rsp_commit) begin
            case ({req_store_q, rsp_hit})
                2'b01:   if (load_hits    != '1) load_hits    <= load_hits    + CNT_W'(1);
                2'b00:   if (load_misses  != '1) load_misses  <= load_misses  + CNT_W'(1);
                2'b11:   if (store_hits   != '1) store_hits   <= store_hits   + CNT_W'(1);
                default: if (store_misses != '1) store_misses <= store_misses + CNT_W'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed scoreboard bench: dut0 is no-write-allocate with wide counters,
// dut1 is write-allocate with 2-bit counters; both use 16 sets x 4 ways.
`timescale 1ns/1ps
module tb_set_assoc_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_store [2];
    logic        flush     [2];
    logic [31:0] req_addr  [2];
    logic        req_ready [2];
    logic        flush_busy[2];
    logic        rsp_valid [2];
    logic        rsp_hit   [2];
    logic [1:0]  rsp_way   [2];
    logic [31:0] lh0, lm0, sh0, sm0;
    logic [1:0]  lh1, lm1, sh1, sm1;

    typedef struct {
        int         d;
        logic       hit;
        logic [1:0] way;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    set_assoc_cache_ctrl #(.ADDR_W(32), .OFFSET_W(2), .INDEX_W(4), .WAYS(4),
                           .WRITE_ALLOC(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_store(req_store[0]), .req_addr(req_addr[0]), .flush(flush[0]),
        .flush_busy(flush_busy[0]), .rsp_valid(rsp_valid[0]), .rsp_hit(rsp_hit[0]),
        .rsp_way(rsp_way[0]), .load_hits(lh0), .load_misses(lm0),
        .store_hits(sh0), .store_misses(sm0));

    set_assoc_cache_ctrl #(.ADDR_W(32), .OFFSET_W(2), .INDEX_W(4), .WAYS(4),
                           .WRITE_ALLOC(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_store(req_store[1]), .req_addr(req_addr[1]), .flush(flush[1]),
        .flush_busy(flush_busy[1]), .rsp_valid(rsp_valid[1]), .rsp_hit(rsp_hit[1]),
        .rsp_way(rsp_way[1]), .load_hits(lh1), .load_misses(lm1),
        .store_hits(sh1), .store_misses(sm1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every response strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                exp_t e;
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid[d]), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_dut",     64'(d),          64'(e.d));
                    check("rsp_hit",     64'(rsp_hit[d]), 64'(e.hit));
                    check("rsp_way",     64'(rsp_way[d]), 64'(e.way));
                    check("rsp_latency", 64'(cyc),        64'(e.cyc));
                end
            end
        end
    end

    task automatic access(input int d, input logic st, input logic [31:0] a,
                          input logic eh, input logic [1:0] ew);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(req_ready[d]), 64'd1);
        req_valid[d] = 1'b1;
        req_store[d] = st;
        req_addr[d]  = a;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        // Accept edge leaves cyc = T; RESP cycle is sampled with cyc = T+1
        sbq.push_back('{d, eh, ew, cyc + 1});
        n = 0;
        while (sbq.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rsp_timeout", 64'(sbq.size()), 64'd0);
        if (sbq.size() != 0) sbq.delete();
    endtask

    task automatic do_flush(input int d, input logic with_req, input logic [31:0] a);
        int n;
        @(negedge clk);
        flush[d]     = 1'b1;
        req_valid[d] = with_req;
        req_store[d] = 1'b0;
        req_addr[d]  = a;
        #1;
        check("ready_while_flush", 64'(req_ready[d]), 64'd0);
        @(posedge clk);
        #1;
        flush[d]     = 1'b0;
        req_valid[d] = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (flush_busy[d] !== 1'b1) break;
            n++;
        end
        check("flush_busy_cycles", 64'(n), 64'd16);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_store[d] = 1'b0;
            flush[d]     = 1'b0;
            req_addr[d]  = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ready",      64'(req_ready[0]),  64'd0);
        check("rst_flush_busy", 64'(flush_busy[0]), 64'd1);
        check("rst_rsp_valid",  64'(rsp_valid[0]),  64'd0);
        check("rst_rsp_way",    64'(rsp_way[0]),    64'd0);

        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready[0] === 1'b1) break;
        end
        check("init_cycles",  64'(n),            64'd16);
        check("init_ready1",  64'(req_ready[1]), 64'd1);
        check("init_busy",    64'(flush_busy[0]), 64'd0);
        check("init_counts0", 64'({lh0, lm0, sh0, sm0}), 64'd0);
        check("init_counts1", 64'({lh1, lm1, sh1, sm1}), 64'd0);

        // Miss then hit on the same line
        access(0, 1'b0, 32'h0001_0000, 1'b0, 2'd0);
        access(0, 1'b0, 32'h0001_0000, 1'b1, 2'd0);
        check("lm_after_pair", 64'(lm0), 64'd1);
        check("lh_after_pair", 64'(lh0), 64'd1);

        // Flush beats a simultaneous request and invalidates everything
        do_flush(0, 1'b1, 32'h0001_0000);
        access(0, 1'b0, 32'h0001_0000, 1'b0, 2'd0);
        check("lm_after_flush", 64'(lm0), 64'd2);

        // Fill set 0 with tags 1..4, then LRU eviction
        do_flush(0, 1'b0, 32'h0);
        for (int t = 1; t <= 4; t++) access(0, 1'b0, 32'(t) << 6, 1'b0, 2'(t - 1));
        access(0, 1'b0, 32'(5) << 6, 1'b0, 2'd0);
        access(0, 1'b0, 32'(1) << 6, 1'b0, 2'd1);
        access(0, 1'b0, 32'(3) << 6, 1'b1, 2'd2);

        // No write-allocate: store miss leaves the set alone
        access(0, 1'b1, 32'h0002_0000, 1'b0, 2'd0);
        check("sm_no_alloc", 64'(sm0), 64'd1);
        access(0, 1'b0, 32'h0002_0000, 1'b0, 2'd3);
        access(0, 1'b1, 32'h0002_0000, 1'b1, 2'd3);
        check("final_lh0", 64'(lh0), 64'd2);
        check("final_lm0", 64'(lm0), 64'd9);
        check("final_sh0", 64'(sh0), 64'd1);
        check("final_sm0", 64'(sm0), 64'd1);

        // Write-allocate store miss, then saturating load-hit counter
        access(1, 1'b1, 32'h0002_0000, 1'b0, 2'd0);
        check("sm_alloc", 64'(sm1), 64'd1);
        for (int i = 0; i < 3; i++) access(1, 1'b0, 32'h0002_0000, 1'b1, 2'd0);
        check("lh1_three", 64'(lh1), 64'd3);
        access(1, 1'b0, 32'h0002_0000, 1'b1, 2'd0);
        check("lh1_saturated", 64'(lh1), 64'd3);
        check("lm1_none",      64'(lm1), 64'd0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/set_assoc_cache_ctrl.md
SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: request address width.
REQ-002 Parameter OFFSET_W, default 2: byte-offset bits (addr[OFFSET_W-1:0]), ignored for lookup.
REQ-003 Parameter INDEX_W, default 14: set-index bits (addr[OFFSET_W+INDEX_W-1:OFFSET_W]); sets = 2^INDEX_W.
REQ-004 Parameter WAYS, default 4: associativity, power of 2, range 1..16; tag width TAG_W = ADDR_W-INDEX_W-OFFSET_W.
REQ-005 Parameter WRITE_ALLOC, default 0: 1 = store miss allocates a line; 0 = store miss leaves array unchanged.
REQ-006 Parameter CNT_W, default 32: statistics counter width.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 req_valid  in  1  access request present.
REQ-010 req_ready  out  1  block accepts a request this cycle.
REQ-011 req_store  in  1  1 = store, 0 = load.
REQ-012 req_addr  in  ADDR_W  access address.
REQ-013 flush  in  1  invalidate-all request, sampled only in IDLE.
REQ-014 flush_busy  out  1  invalidation sweep in progress.
REQ-015 rsp_valid  out  1  one-cycle result strobe.
REQ-016 rsp_hit  out  1  result: 1 = hit.
REQ-017 rsp_way  out  log2(WAYS) (min 1)  way hit or allocated; 0 when store miss with WRITE_ALLOC=0.
REQ-018 load_hits, load_misses, store_hits, store_misses  out  CNT_W each  access statistics.

Function
REQ-019 FSM states SHALL be INIT, IDLE, LOOKUP, RESP, FLUSH.
REQ-020 req_ready SHALL be 1 only in IDLE with flush low; a request is accepted when req_valid && req_ready.
REQ-021 Accepted request at edge T SHALL be registered (store flag, tag, index); LOOKUP occupies cycle T+1; RESP occupies T+2 with rsp_valid=1 for exactly one cycle; state returns to IDLE at T+3 (throughput one access per 3 cycles).
REQ-022 Hit SHALL be valid[set][w] && tag[set][w]==req tag for some way w; at most one way may match.
REQ-023 Victim selection on allocating miss: lowest-numbered invalid way; if all valid, the way with maximum LRU age.
REQ-024 Per-set LRU ages (log2(WAYS) bits per way) SHALL form a permutation of 0..WAYS-1 after any update; on hit or allocation of way w: ways with age < age[w] increment, age[w] becomes 0, others unchanged.
REQ-025 Load miss SHALL always allocate; store miss SHALL allocate only if WRITE_ALLOC=1; no allocation means no tag, valid or LRU change.
REQ-026 Array/LRU updates and counter increments SHALL take effect at the RESP edge, visible to the next accepted request.
REQ-027 Exactly one counter SHALL increment per response, selected by (req_store, rsp_hit); counters saturate at 2^CNT_W-1.
REQ-028 flush high in IDLE SHALL enter FLUSH (priority over simultaneous req_valid, which is not accepted); FLUSH clears valid bits and resets LRU ages to way number for one set per cycle, index 0 upward, 2^INDEX_W cycles, then IDLE; counters unaffected.
REQ-029 flush_busy SHALL be 1 in INIT and FLUSH, 0 otherwise; flush asserted outside IDLE is ignored.

Reset
REQ-030 rst high SHALL asynchronously force state INIT, sweep index 0, req_ready=0, rsp_valid=0, rsp_hit=0, rsp_way=0, all four counters 0.
REQ-031 After rst deasserts, INIT SHALL sweep all sets as in REQ-028 (2^INDEX_W cycles), then IDLE; rst mid-access or mid-flush discards the access with no response.

Verification (INDEX_W=4, WAYS=4, OFFSET_W=2, ADDR_W=32)
REQ-032 Reset release -> req_ready rises after exactly 16 cycles; all counters 0.
REQ-033 Load 0x00010000 twice -> first rsp_hit=0 rsp_way=0, second rsp_hit=1 rsp_way=0; load_misses=1, load_hits=1; rsp_valid exactly 2 cycles after each acceptance.
REQ-034 Loads to tags 1..5 at set 0, then tag 1 -> fifth load evicts way 0 (tag 1), sixth load misses and replaces way 1 (tag 2, then LRU).
REQ-035 WRITE_ALLOC=0: store miss 0x00020000 then load same -> store_misses=1, rsp_way=0, load misses; WRITE_ALLOC=1: load hits.
REQ-036 flush and req_valid high together in IDLE -> request not accepted, flush_busy high 16 cycles, subsequent load to previously cached address misses.
REQ-037 CNT_W=2: four load hits -> load_hits saturates at 3.
